// File: rtl/nvram_backup_ctrl.sv
// Save-RAM backup sequencer: loads the SAV image sector by sector on mount and writes it
// back on a manual request or after an idle period following core nvram writes.
module nvram_backup_ctrl #(
  parameter int unsigned SECTORS      = 16,
  parameter logic [23:0] AUTOSAVE_CYC = 24'd10_000_000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        img_mounted,
  input  logic [31:0] img_size,
  input  logic        download,
  input  logic        save_req,
  input  logic        autosave,
  input  logic        nvram_we,
  input  logic        sd_ack,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  output logic        bk_ena,
  output logic        bk_busy,
  output logic        bk_dirty,
  output logic        bk_reset
);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, XFER, STEP} state_e;
  typedef enum logic {OP_LOAD, OP_SAVE} op_e;

  localparam logic [31:0] LAST_LBA = 32'(SECTORS - 1);

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [31:0] lba_q, lba_d;
  logic        rd_q, rd_d, wr_q, wr_d;
  logic        ena_q, ena_d;
  logic        load_pend_q, load_pend_d;
  logic        save_pend_q, save_pend_d;
  logic        dirty_q, dirty_d;
  logic        rst_pulse_q, rst_pulse_d;
  logic        abort_q, abort_d;
  logic [23:0] idle_cnt_q, idle_cnt_d;
  logic        mnt_prev_q, save_prev_q, dl_prev_q, ack_prev_q;

  logic mnt_rise, save_rise, dl_rise, ack_rise, ack_fall, mnt_valid;
  logic start_load, start_save, load_done, load_active, save_trig;

  assign mnt_rise  = img_mounted & ~mnt_prev_q;
  assign save_rise = save_req & ~save_prev_q;
  assign dl_rise   = download & ~dl_prev_q;
  assign ack_rise  = sd_ack & ~ack_prev_q;
  assign ack_fall  = ~sd_ack & ack_prev_q;
  assign mnt_valid = (img_size != 32'd0);

  // STEP sits between the ack fall and the next command so both the next
  // sector and the bk_reset pulse appear two cycles after the fall.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    op_d        = op_q;
    lba_d       = lba_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    rst_pulse_d = 1'b0;
    start_load  = 1'b0;
    start_save  = 1'b0;
    load_done   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!dl_rise && ena_q && load_pend_q) begin
          op_d       = OP_LOAD;
          lba_d      = 32'd0;
          rd_d       = 1'b1;
          state_d    = WAIT_ACK;
          start_load = 1'b1;
        end else if (!dl_rise && ena_q && save_pend_q) begin
          op_d       = OP_SAVE;
          lba_d      = 32'd0;
          wr_d       = 1'b1;
          state_d    = WAIT_ACK;
          start_save = 1'b1;
        end
      end
      WAIT_ACK: begin
        if (ack_rise) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = XFER;
        end
      end
      XFER: begin
        if (ack_fall) state_d = STEP;
      end
      STEP: begin
        if (lba_q == LAST_LBA || abort_q) begin
          state_d = IDLE;
          if (op_q == OP_LOAD && !abort_q) begin
            rst_pulse_d = 1'b1;
            load_done   = 1'b1;
          end
        end else begin
          lba_d   = lba_q + 32'd1;
          rd_d    = (op_q == OP_LOAD);
          wr_d    = (op_q == OP_SAVE);
          state_d = WAIT_ACK;
        end
      end
      default: state_d = IDLE;
    endcase
    abort_d = (state_d != IDLE) && (abort_q || dl_rise);
  end

  assign load_active = ((state_q != IDLE) && (op_q == OP_LOAD)) || start_load;

  always_comb begin
    ena_d = ena_q;
    if (mnt_rise) ena_d = mnt_valid;
    if (dl_rise)  ena_d = 1'b0;

    // The next-cycle enable lets a save request coincident with a mount be kept.
    save_trig = ena_d & (save_rise |
                (autosave & dirty_q & (idle_cnt_q == AUTOSAVE_CYC) & ~save_pend_q));

    load_pend_d = load_pend_q;
    if (start_load) load_pend_d = 1'b0;
    if (mnt_rise)   load_pend_d = mnt_valid;
    if (dl_rise)    load_pend_d = 1'b0;

    save_pend_d = save_pend_q;
    if (start_save) save_pend_d = 1'b0;
    if (save_trig)  save_pend_d = 1'b1;
    if (dl_rise)    save_pend_d = 1'b0;

    dirty_d = dirty_q;
    if (start_save || load_done)   dirty_d = 1'b0;
    if (nvram_we && !load_active)  dirty_d = 1'b1;
    if (dl_rise)                   dirty_d = 1'b0;

    idle_cnt_d = idle_cnt_q;
    if (dirty_q && state_q == IDLE && idle_cnt_q < AUTOSAVE_CYC) idle_cnt_d = idle_cnt_q + 24'd1;
    if (start_save || nvram_we) idle_cnt_d = 24'd0;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= OP_LOAD;
      lba_q       <= 32'd0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      ena_q       <= 1'b0;
      load_pend_q <= 1'b0;
      save_pend_q <= 1'b0;
      dirty_q     <= 1'b0;
      rst_pulse_q <= 1'b0;
      abort_q     <= 1'b0;
      idle_cnt_q  <= 24'd0;
      mnt_prev_q  <= 1'b0;
      save_prev_q <= 1'b0;
      dl_prev_q   <= 1'b0;
      ack_prev_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      op_q        <= op_d;
      lba_q       <= lba_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      ena_q       <= ena_d;
      load_pend_q <= load_pend_d;
      save_pend_q <= save_pend_d;
      dirty_q     <= dirty_d;
      rst_pulse_q <= rst_pulse_d;
      abort_q     <= abort_d;
      idle_cnt_q  <= idle_cnt_d;
      mnt_prev_q  <= img_mounted;
      save_prev_q <= save_req;
      dl_prev_q   <= download;
      ack_prev_q  <= sd_ack;
    end
  end

  assign sd_lba   = lba_q;
  assign sd_rd    = rd_q;
  assign sd_wr    = wr_q;
  assign bk_ena   = ena_q;
  assign bk_busy  = (state_q != IDLE);
  assign bk_dirty = dirty_q;
  assign bk_reset = rst_pulse_q;

endmodule

// File: tb/tb_nvram_backup_ctrl.sv
// Bench for nvram_backup_ctrl: a randomized SD-card responder checks every sector command
// against a queue of expected transfers built from the backup rules.
module tb_nvram_backup_ctrl;

  localparam int          SECTORS      = 16;
  localparam logic [23:0] AUTOSAVE_CYC = 24'd100;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        img_mounted;
  logic [31:0] img_size;
  logic        download;
  logic        save_req;
  logic        autosave;
  logic        nvram_we;
  logic        sd_ack;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        bk_ena;
  logic        bk_busy;
  logic        bk_dirty;
  logic        bk_reset;

  nvram_backup_ctrl #(.SECTORS(SECTORS), .AUTOSAVE_CYC(AUTOSAVE_CYC)) dut (
    .clk_sys(clk_sys), .reset(reset), .img_mounted(img_mounted), .img_size(img_size),
    .download(download), .save_req(save_req), .autosave(autosave), .nvram_we(nvram_we),
    .sd_ack(sd_ack), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .bk_ena(bk_ena),
    .bk_busy(bk_busy), .bk_dirty(bk_dirty), .bk_reset(bk_reset)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic        wr;
    logic [31:0] lba;
  } xfer_t;

  xfer_t exp_q[$];
  int    n_checks    = 0;
  int    n_fail      = 0;
  int    exp_resets  = 0;
  int    seen_resets = 0;
  bit    resp_en     = 1'b1;
  int    hold_min    = 4;
  int    hold_max    = 12;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_job(input logic wr, input int first, input int last);
    xfer_t t;
    for (int i = first; i <= last; i++) begin
      t.wr  = wr;
      t.lba = 32'(i);
      exp_q.push_back(t);
    end
  endtask

  task automatic wait_done(input string tag, input int limit);
    int n = 0;
    while ((exp_q.size() != 0 || bk_busy) && n < limit) begin
      @(negedge clk_sys);
      n++;
    end
    check({tag, "_completes"}, 32'(n < limit), 32'd1);
    repeat (4) @(negedge clk_sys);
  endtask

  task automatic pulse_we();
    @(posedge clk_sys); #1 nvram_we = 1'b1;
    @(posedge clk_sys); #1 nvram_we = 1'b0;
  endtask

  task automatic pulse_save();
    @(posedge clk_sys); #1 save_req = 1'b1;
    repeat (2) @(posedge clk_sys);
    #1 save_req = 1'b0;
  endtask

  task automatic wait_sector(input string tag, input logic [31:0] lba);
    int n = 0;
    while (!(sd_ack && sd_lba == lba) && n < 2000) begin
      @(negedge clk_sys);
      n++;
    end
    check({tag, "_reached"}, 32'(n < 2000), 32'd1);
  endtask

  // Card model: acknowledges each command after a random delay for a random hold time.
  initial begin : responder
    xfer_t cur;
    sd_ack = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (resp_en && (sd_rd || sd_wr)) begin
        if (exp_q.size() == 0) begin
          check("spurious_cmd", {30'd0, sd_wr, sd_rd}, 32'd0);
          cur.wr  = sd_wr;
          cur.lba = sd_lba;
        end else begin
          cur = exp_q.pop_front();
          check("cmd_type", {30'd0, sd_wr, sd_rd}, cur.wr ? 32'd2 : 32'd1);
          check("cmd_lba", sd_lba, cur.lba);
          check("busy_during_cmd", 32'(bk_busy), 32'd1);
        end
        repeat ($urandom_range(1, 3)) @(posedge clk_sys);
        #1 sd_ack = 1'b1;
        @(negedge clk_sys);
        check("cmd_held_at_ack", 32'(sd_rd | sd_wr), 32'd1);
        @(negedge clk_sys);
        check("cmd_dropped_after_ack", 32'(sd_rd | sd_wr), 32'd0);
        repeat (int'($urandom_range(hold_min, hold_max)) - 1) @(posedge clk_sys);
        #1 sd_ack = 1'b0;
        @(negedge clk_sys);
        @(negedge clk_sys);
        check("no_cmd_fall_plus1", 32'(sd_rd | sd_wr), 32'd0);
        check("no_bk_reset_fall_plus1", 32'(bk_reset), 32'd0);
        @(negedge clk_sys);
        if (exp_q.size() != 0 && exp_q[0].wr == cur.wr && exp_q[0].lba == cur.lba + 32'd1) begin
          check("next_cmd_fall_plus2", 32'(sd_rd | sd_wr), 32'd1);
          check("next_lba", sd_lba, cur.lba + 32'd1);
        end else begin
          check("no_cmd_after_job", 32'(sd_rd | sd_wr), 32'd0);
        end
        if (!cur.wr && cur.lba == 32'(SECTORS - 1))
          check("bk_reset_pulse", 32'(bk_reset), 32'd1);
      end
    end
  end

  always @(negedge clk_sys) if (bk_reset) seen_resets++;

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    int k;
    int n;
    reset = 1'b1; img_mounted = 1'b0; img_size = 32'd0; download = 1'b0;
    save_req = 1'b0; autosave = 1'b0; nvram_we = 1'b0;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    check("rst_lba", sd_lba, 32'd0);
    check("rst_rd", 32'(sd_rd), 32'd0);
    check("rst_wr", 32'(sd_wr), 32'd0);
    check("rst_ena", 32'(bk_ena), 32'd0);
    check("rst_busy", 32'(bk_busy), 32'd0);
    check("rst_dirty", 32'(bk_dirty), 32'd0);
    check("rst_bk_reset", 32'(bk_reset), 32'd0);
    @(posedge clk_sys); #1 reset = 1'b0;

    // Save request with no image mounted does nothing.
    pulse_save();
    repeat (40) @(negedge clk_sys);
    check("save_no_ena_busy", 32'(bk_busy), 32'd0);

    // Mount and save request in the same cycle: full load, then full save.
    hold_min = 20; hold_max = 20;
    push_job(1'b0, 0, SECTORS - 1);
    push_job(1'b1, 0, SECTORS - 1);
    exp_resets++;
    @(posedge clk_sys); #1 img_size = 32'd8192; img_mounted = 1'b1; save_req = 1'b1;
    @(negedge clk_sys); check("mount_rd_n0", 32'(sd_rd), 32'd0);
    @(negedge clk_sys); check("mount_rd_n1", 32'(sd_rd), 32'd0);
    @(negedge clk_sys); check("mount_rd_n2", 32'(sd_rd), 32'd1);
    check("mount_lba0", sd_lba, 32'd0);
    check("mount_ena", 32'(bk_ena), 32'd1);
    @(posedge clk_sys); #1 save_req = 1'b0;
    wait_done("load_then_save", 3000);
    check("load_dirty", 32'(bk_dirty), 32'd0);
    check("load_resets", 32'(seen_resets), 32'(exp_resets));
    hold_min = 4; hold_max = 12;

    // Manual save after a write; a write during the save leaves the buffer dirty.
    pulse_we();
    @(negedge clk_sys); check("dirty_after_we", 32'(bk_dirty), 32'd1);
    push_job(1'b1, 0, SECTORS - 1);
    @(posedge clk_sys); #1 save_req = 1'b1;
    @(negedge clk_sys); check("save_wr_n0", 32'(sd_wr), 32'd0);
    @(negedge clk_sys); check("save_wr_n1", 32'(sd_wr), 32'd0);
    check("save_dirty_n1", 32'(bk_dirty), 32'd1);
    @(negedge clk_sys); check("save_wr_n2", 32'(sd_wr), 32'd1);
    check("save_dirty_n2", 32'(bk_dirty), 32'd0);
    #1 save_req = 1'b0;
    wait_sector("save_sector3", 32'd3);
    pulse_we();
    wait_done("manual_save", 2000);
    check("dirty_after_write_in_save", 32'(bk_dirty), 32'd1);
    check("save_no_bk_reset", 32'(seen_resets), 32'(exp_resets));

    // Autosave: fires AUTOSAVE_CYC+2 (+-1) cycles after the last write.
    push_job(1'b1, 0, SECTORS - 1);
    @(posedge clk_sys); #1 nvram_we = 1'b1;
    @(posedge clk_sys); #1 nvram_we = 1'b0; autosave = 1'b1;
    k = 0;
    do begin @(negedge clk_sys); k++; end while (!sd_wr && k < 300);
    check("autosave_latency_102pm1", 32'(k >= 101 && k <= 103), 32'd1);
    check("autosave_dirty_cleared", 32'(bk_dirty), 32'd0);
    wait_done("autosave1", 2000);

    push_job(1'b1, 0, SECTORS - 1);
    @(posedge clk_sys); #1 nvram_we = 1'b1;
    @(posedge clk_sys); #1 nvram_we = 1'b0;
    repeat (49) @(posedge clk_sys);
    #1 nvram_we = 1'b1;
    @(posedge clk_sys); #1 nvram_we = 1'b0;
    k = 50;
    do begin @(negedge clk_sys); k++; end while (!sd_wr && k < 400);
    check("autosave_retrigger_152pm1", 32'(k >= 151 && k <= 153), 32'd1);
    wait_done("autosave2", 2000);
    autosave = 1'b0;

    // Download during sector 5 of a save: sector 5 completes, then everything stops.
    push_job(1'b1, 0, 5);
    pulse_save();
    wait_sector("dl_sector2", 32'd2);
    pulse_we();
    wait_sector("dl_sector5", 32'd5);
    check("dl_dirty_before", 32'(bk_dirty), 32'd1);
    @(posedge clk_sys); #1 download = 1'b1;
    wait_done("download_abort", 500);
    check("dl_ena", 32'(bk_ena), 32'd0);
    check("dl_dirty", 32'(bk_dirty), 32'd0);
    repeat (60) @(negedge clk_sys);
    check("dl_idle", 32'(bk_busy), 32'd0);
    download = 1'b0;

    // Asynchronous reset while a read command is up, then a clean reload.
    resp_en = 1'b0;
    @(posedge clk_sys); #1 img_mounted = 1'b0;
    @(posedge clk_sys); #1 img_mounted = 1'b1;
    n = 0;
    while (!sd_rd && n < 20) begin @(negedge clk_sys); n++; end
    check("pre_reset_rd", 32'(sd_rd), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_rd", 32'(sd_rd), 32'd0);
    check("async_rst_wr", 32'(sd_wr), 32'd0);
    check("async_rst_lba", sd_lba, 32'd0);
    check("async_rst_ena", 32'(bk_ena), 32'd0);
    check("async_rst_busy", 32'(bk_busy), 32'd0);
    check("async_rst_bk_reset", 32'(bk_reset), 32'd0);
    img_mounted = 1'b0;
    @(posedge clk_sys); #1 reset = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("post_rst_busy", 32'(bk_busy), 32'd0);
    resp_en = 1'b1;
    push_job(1'b0, 0, SECTORS - 1);
    exp_resets++;
    @(posedge clk_sys); #1 img_mounted = 1'b1;
    wait_sector("reload_sector2", 32'd2);
    pulse_we();
    wait_done("reload", 2000);
    check("reload_dirty_ignores_we", 32'(bk_dirty), 32'd0);
    check("reload_ena", 32'(bk_ena), 32'd1);

    // Mount of an empty image disables backup; a save request is then ignored.
    @(posedge clk_sys); #1 img_mounted = 1'b0; img_size = 32'd0;
    @(posedge clk_sys); #1 img_mounted = 1'b1;
    repeat (3) @(negedge clk_sys);
    check("empty_mount_ena", 32'(bk_ena), 32'd0);
    pulse_save();
    repeat (30) @(negedge clk_sys);
    check("empty_mount_busy", 32'(bk_busy), 32'd0);

    check("bk_reset_pulses", 32'(seen_resets), 32'(exp_resets));
    check("expected_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
